// File: rtl/motor_input_cond.sv
// Input conditioner for the motor up/down controller: synchronizes and debounces button and limit switches,
// emits one activate pulse per press, and flags a sticky both-limits fault. Optional macro: MOTOR_COND_LOCKOUT_EN.
module motor_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 100000,
    parameter int unsigned LOCK_W          = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_raw,
    input  logic up_n_raw,
    input  logic dn_n_raw,
    input  logic fault_clr,
    output logic activate,
    output logic up_limit,
    output logic dn_limit,
    output logic limit_fault
);

    localparam int NCH = 3;
    localparam int BTN = 0;
    localparam int UP  = 1;
    localparam int DN  = 2;

    if (DEBOUNCE_CYCLES < 2 || CNT_W < 1 || LOCKOUT_CYCLES < 1 || LOCK_W < 1) begin : g_bad_param
        $error("motor_input_cond: illegal parameter value");
    end

`ifdef MOTOR_COND_LOCKOUT_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HELD    = 2'd1,
        S_LOCKOUT = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } state_e;
`endif

    logic [NCH-1:0]            sync1_q, sync2_q;
    logic [NCH-1:0]            sync_c;
    logic [NCH-1:0]            deb_q, deb_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                      fault_q, fault_d;
    logic                      activate_q, activate_d;
    state_e                    state_q, state_d;
`ifdef MOTOR_COND_LOCKOUT_EN
    logic [LOCK_W-1:0]         lock_cnt_q, lock_cnt_d;
`endif

    // Two-flop synchronizers; released (high) at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {dn_n_raw, up_n_raw, btn_n_raw};
            sync2_q <= sync1_q;
        end
    end

    assign sync_c = ~sync2_q;

    // Per-channel debounce: any match restarts the count, so short glitches are rejected
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (sync_c[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync_c[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Sticky fault; a set condition wins over a clear request
    always_comb begin
        fault_d = fault_q;
        if (deb_q[UP] && deb_q[DN]) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    // Press FSM: one pulse per debounced press, suppressed while faulted
    always_comb begin
        state_d    = state_q;
        activate_d = 1'b0;
`ifdef MOTOR_COND_LOCKOUT_EN
        lock_cnt_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (deb_q[BTN]) begin
                    state_d    = S_HELD;
                    activate_d = ~fault_q;
                end
            end
            S_HELD: begin
                if (!deb_q[BTN]) begin
`ifdef MOTOR_COND_LOCKOUT_EN
                    state_d = S_LOCKOUT;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef MOTOR_COND_LOCKOUT_EN
            S_LOCKOUT: begin
                if (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d = deb_q[BTN] ? S_HELD : S_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q      <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            activate_q <= 1'b0;
            state_q    <= S_IDLE;
`ifdef MOTOR_COND_LOCKOUT_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            activate_q <= activate_d;
            state_q    <= state_d;
`ifdef MOTOR_COND_LOCKOUT_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign activate    = activate_q;
    assign up_limit    = deb_q[UP];
    assign dn_limit    = deb_q[DN];
    assign limit_fault = fault_q;

endmodule
